// File: rtl/store_unit_pkg.sv
// rtl/store_unit_pkg.sv - opcode constants, size/state encodings and store decode for the store unit

// Shared machine constants (word width, instruction width, store opcodes).
`ifndef STORE_UNIT_CONSTANTS_VH
`define STORE_UNIT_CONSTANTS_VH
`define WORD      64
`define INSTR_LEN 32
`define STUR      11'b11111000000
`define STURW     11'b10111000000
`define STURH     11'b01111000000
`define STURB     11'b00111000000
`endif

package store_unit_pkg;

    // Access size of a store request.
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_e;

    typedef struct packed {
        logic  is_store;
        size_e size;
    } store_dec_t;

    // Map an 11-bit opcode onto a store size; anything else is not a store.
    function automatic store_dec_t decode_store(input logic [10:0] opcode);
        store_dec_t dec;
        dec.is_store = 1'b1;
        dec.size     = SZ_B;
        case (opcode)
            `STUR:   dec.size = SZ_D;
            `STURW:  dec.size = SZ_W;
            `STURH:  dec.size = SZ_H;
            `STURB:  dec.size = SZ_B;
            default: dec.is_store = 1'b0;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/store_unit_lane_format.sv
// rtl/store_unit_lane_format.sv - places store data on byte lanes and flags misalignment

module store_lane_format
    import store_unit_pkg::*;
(
    input  size_e        size_i,
    input  logic [2:0]   addr_i,
    input  logic [63:0]  data_i,
    output logic [3:0]   be_o,
    output logic [31:0]  lane_data_o,
    output logic         misaligned_o
);

    logic [1:0] lane;
    logic [4:0] lane_shift;

    assign lane       = addr_i[1:0];
    assign lane_shift = {lane, 3'b000};

    // Byte enables and lane data per size; unenabled lanes stay zero.
    always_comb begin
        be_o         = 4'b0000;
        lane_data_o  = 32'h0;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_B: begin
                be_o        = 4'b0001 << lane;
                lane_data_o = {24'h0, data_i[7:0]} << lane_shift;
            end
            SZ_H: begin
                misaligned_o = addr_i[0];
                be_o         = 4'b0011 << lane;
                lane_data_o  = {16'h0, data_i[15:0]} << lane_shift;
            end
            SZ_W: begin
                misaligned_o = |addr_i[1:0];
                be_o         = 4'b1111;
                lane_data_o  = data_i[31:0];
            end
            default: begin
                misaligned_o = |addr_i[2:0];
                be_o         = 4'b1111;
                lane_data_o  = data_i[31:0];
            end
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - store request to byte-enabled 32-bit memory write beats

module store_unit
    import store_unit_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int BUS_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [`INSTR_LEN-1:0] instruction,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [`WORD-1:0]      req_data,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [BUS_W-1:0]      mem_wdata,
    output logic [BUS_W/8-1:0]    mem_be,
    output logic                  done,
    output logic                  align_fault
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BUS_W-1:0]    wdata_q, wdata_d;
    logic [BUS_W/8-1:0]  be_q, be_d;
    logic [BUS_W-1:0]    hi_q, hi_d;
    logic                two_beat_q, two_beat_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;

    store_dec_t          dec;
    logic [3:0]          fmt_be;
    logic [31:0]         fmt_data;
    logic                fmt_misaligned;
    logic                unused_instr_bits;

    assign dec               = decode_store(instruction[31:21]);
    assign unused_instr_bits = ^instruction[20:0];

    store_lane_format u_fmt (
        .size_i       (dec.size),
        .addr_i       (req_addr[2:0]),
        .data_i       (req_data),
        .be_o         (fmt_be),
        .lane_data_o  (fmt_data),
        .misaligned_o (fmt_misaligned)
    );

    assign req_ready   = (state_q == ST_IDLE);
    assign mem_valid   = (state_q != ST_IDLE);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_be      = be_q;
    assign done        = done_q;
    assign align_fault = fault_q;

    // State and beat registers; reset abandons any store in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            hi_q       <= '0;
            two_beat_q <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            hi_q       <= hi_d;
            two_beat_q <= two_beat_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
        end
    end

    // Accept/decode in IDLE, hold each beat until mem_ready, then pulse done.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        hi_d       = hi_q;
        two_beat_d = two_beat_q;
        done_d     = 1'b0;
        fault_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && dec.is_store) begin
                    if (fmt_misaligned) begin
                        fault_d = 1'b1;
                    end else begin
                        state_d    = ST_BEAT0;
                        addr_d     = {req_addr[ADDR_W-1:2], 2'b00};
                        wdata_d    = fmt_data;
                        be_d       = fmt_be;
                        hi_d       = req_data[63:32];
                        two_beat_d = (dec.size == SZ_D);
                    end
                end
            end
            ST_BEAT0: begin
                if (mem_ready) begin
                    if (two_beat_q) begin
                        state_d = ST_BEAT1;
                        addr_d  = addr_q + ADDR_W'(4);
                        wdata_d = hi_q;
                        be_d    = '1;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        addr_d  = '0;
                        wdata_d = '0;
                        be_d    = '0;
                    end
                end
            end
            ST_BEAT1: begin
                if (mem_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    addr_d  = '0;
                    wdata_d = '0;
                    be_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
